// File: rtl/fizzbuzz_sequencer.sv
// Steps n = 1..limit through an external fizzbuzz stage and streams one token per value,
// keeping running fizz/buzz totals for the current run.
module fizzbuzz_sequencer #(
  parameter int BITS = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [BITS-1:0] limit,
  output logic [BITS-1:0] fb_n,
  input  logic            fb_fizz,
  input  logic            fb_buzz,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_num,
  output logic [1:0]      out_kind,
  output logic            out_last,
  output logic            busy,
  output logic [BITS-1:0] fizz_count,
  output logic [BITS-1:0] buzz_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] cnt_q, cnt_d;
  logic [BITS-1:0] limit_q, limit_d;
  logic [BITS-1:0] num_q, num_d;
  logic [1:0]      kind_q, kind_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic [BITS-1:0] fizz_q, fizz_d;
  logic [BITS-1:0] buzz_q, buzz_d;
  logic            slot_free;
  logic            handshake;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    limit_d   = limit_q;
    num_d     = num_q;
    kind_d    = kind_q;
    valid_d   = valid_q;
    last_d    = last_q;
    fizz_d    = fizz_q;
    buzz_d    = buzz_q;
    slot_free = !valid_q || out_ready;
    handshake = valid_q && out_ready;

    // Totals follow accepted tokens, so they lag capture by the handshake.
    if (handshake) begin
      fizz_d = fizz_q + BITS'(kind_q[0]);
      buzz_d = buzz_q + BITS'(kind_q[1]);
    end

    case (state_q)
      S_IDLE: begin
        if (start && (limit != '0)) begin
          limit_d = limit;
          cnt_d   = BITS'(1);
          fizz_d  = '0;
          buzz_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (slot_free) begin
          valid_d = 1'b1;
          num_d   = cnt_q;
          kind_d  = {fb_buzz, fb_fizz};
          last_d  = (cnt_q == limit_q);
          if (cnt_q == limit_q) state_d = S_DRAIN;
          else                  cnt_d   = cnt_q + BITS'(1);
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      limit_q <= '0;
      num_q   <= '0;
      kind_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      fizz_q  <= '0;
      buzz_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      num_q   <= num_d;
      kind_q  <= kind_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      fizz_q  <= fizz_d;
      buzz_q  <= buzz_d;
    end
  end

  assign fb_n       = (state_q == S_RUN) ? cnt_q : '0;
  assign out_valid  = valid_q;
  assign out_num    = num_q;
  assign out_kind   = kind_q;
  assign out_last   = last_q;
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign fizz_count = fizz_q;
  assign buzz_count = buzz_q;

endmodule
